// File: rtl/spram_stream_fifo_pkg.sv
// Helpers shared by the SPRAM stream FIFO files.
// Holds functions only; every width comes from the module parameters.
package spram_stream_fifo_pkg;

  function automatic int unsigned wrap_inc(input int unsigned value, input int unsigned depth);
    return (value == depth - 1) ? 0 : value + 1;
  endfunction

endpackage

// File: rtl/spram_stream_fifo_spram.sv
// Single-port RAM with a registered read port: rdata is valid one cycle after a read.
// Port convention: en=1 with wr=0 writes, en=1 with wr=1 reads.
module SPRAM #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DEPTH         = 1024,
  parameter              RAM_STYLE_VAL = "block",
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  wr,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  (* ram_style = RAM_STYLE_VAL *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (!wr) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/spram_stream_fifo.sv
// Stream FIFO backed by one single-port RAM plus a 2-entry output buffer.
// Reads take priority over writes; the buffer hides the one-cycle RAM read latency.
module spram_stream_fifo
  import spram_stream_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024,
  localparam int unsigned CW = $clog2(DEPTH + 3)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CW-1:0]         count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned MW = $clog2(DEPTH + 1);

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [MW-1:0]         mem_count;
  logic                  rd_pending;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  head;
  logic [1:0]            buf_cnt;

  logic                  rd_issue;
  logic                  accept;
  logic                  pop;
  logic                  capture;
  logic                  tail;
  logic                  ram_en;
  logic                  ram_wr;
  logic [PW-1:0]         ram_addr;
  logic [DATA_WIDTH-1:0] rdata;

  always_comb begin
    rd_issue  = 1'b0;
    in_ready  = 1'b0;
    accept    = 1'b0;
    out_valid = 1'b0;
    pop       = 1'b0;
    capture   = 1'b0;
    tail      = 1'b0;
    ram_en    = 1'b0;
    ram_wr    = 1'b0;
    ram_addr  = wr_ptr;

    rd_issue  = (mem_count != '0) && ((buf_cnt + {1'b0, rd_pending}) < 2'd2);
    // Gated by reset_n so in_ready drops asynchronously while reset is held.
    in_ready  = reset_n && !clear && (mem_count < MW'(DEPTH)) && !rd_issue;
    accept    = in_valid && in_ready;
    out_valid = (buf_cnt != 2'd0);
    pop       = out_valid && out_ready;
    capture   = rd_pending && !clear;
    tail      = head ^ buf_cnt[0];
    ram_en    = rd_issue || accept;
    ram_wr    = rd_issue;
    ram_addr  = rd_issue ? rd_ptr : wr_ptr;
  end

  assign out_data = buf_q[head];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_count  <= '0;
      rd_pending <= 1'b0;
      head       <= 1'b0;
      buf_cnt    <= '0;
      count      <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_q[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_count  <= '0;
      rd_pending <= 1'b0;
      head       <= 1'b0;
      buf_cnt    <= '0;
      count      <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= PW'(wrap_inc(32'(wr_ptr), DEPTH));
      end
      if (rd_issue) begin
        rd_ptr <= PW'(wrap_inc(32'(rd_ptr), DEPTH));
      end
      mem_count  <= mem_count + MW'(accept) - MW'(rd_issue);
      rd_pending <= rd_issue;
      // Capture lands behind the current head, so a same-cycle pop is safe.
      if (capture) begin
        buf_q[tail] <= rdata;
      end
      if (pop) begin
        head <= ~head;
      end
      buf_cnt <= buf_cnt + {1'b0, capture} - {1'b0, pop};
      count   <= count + CW'(accept) - CW'(pop);
    end
  end

  SPRAM #(
    .DATA_WIDTH    (DATA_WIDTH),
    .DEPTH         (DEPTH),
    .RAM_STYLE_VAL ("block")
  ) u_spram (
    .clk   (clock),
    .en    (ram_en),
    .wr    (ram_wr),
    .addr  (ram_addr),
    .wdata (in_data),
    .rdata (rdata)
  );

endmodule

// File: doc/spram_stream_fifo.md
SPRAM_STREAM_FIFO -- requirements
Module: spram_stream_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of every stored word.
REQ-002 SHALL have parameter DEPTH, default 1024: number of SPRAM words, at least 2, need not be a power of two.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port clear, input, 1 bit: synchronous flush of all stored data.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream word valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-008 SHALL have port in_data, input, DATA_WIDTH bits: upstream word.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data holds a valid word.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the word.
REQ-011 SHALL have port out_data, output, DATA_WIDTH bits: oldest word.
REQ-012 SHALL have port count, output, $clog2(DEPTH+3) bits: words held, memory plus output buffer.

Function
REQ-013 SHALL store words in one SPRAM instance; per cycle only a write (en=1, wr=0) or a read (en=1, wr=1) is issued; read data appears on rdata one cycle after the read.
REQ-014 SHALL track wr_ptr, rd_ptr and mem_count; each pointer wraps from DEPTH-1 to 0.
REQ-015 SHALL keep a 2-entry output buffer; a read is issued only when buffer occupancy plus in-flight reads is below 2 and mem_count > 0.
REQ-016 SHALL give reads priority over writes in the same cycle; in_ready = (mem_count < DEPTH) and no read issued this cycle, with no dependence on in_valid.
REQ-017 SHALL write in_data at wr_ptr when in_valid and in_ready are both high, then increment wr_ptr and mem_count.
REQ-018 SHALL capture rdata into the output buffer in the cycle after the read; out_valid = buffer non-empty; out_data = buffer head.
REQ-019 SHALL pop the buffer head on out_valid and out_ready; a pop and a capture in the same cycle SHALL both take effect.
REQ-020 SHALL give latency: a word accepted in cycle N with the block otherwise empty SHALL be on out_valid in cycle N+3.
REQ-021 SHALL deliver words in acceptance order with no loss or duplication across pointer wrap.
REQ-022 SHALL update count each cycle by +1 on accept and -1 on pop, so a simultaneous accept and pop leaves count unchanged.
REQ-023 SHALL, with clear high, zero pointers, mem_count, buffer and count at the next edge, discard any in-flight read result, and drop any in_data offered that cycle with in_ready forced low.
REQ-024 SHALL deassert in_ready when full (mem_count == DEPTH) and SHALL issue no read when empty; out_valid SHALL hold until out_ready.

Reset
REQ-025 SHALL, with reset_n low, asynchronously force in_ready=0, out_valid=0, out_data=0, count=0, pointers=0, mem_count=0, in-flight flag=0; SPRAM contents are undefined.
REQ-026 SHALL raise in_ready in the first cycle after reset_n deasserts.

Structure
REQ-027 SHALL hold no shared-package typedefs or constants; all widths derive from DATA_WIDTH and DEPTH.
REQ-028 SHALL instantiate exactly one sub-module, SPRAM, with DATA_WIDTH and DEPTH passed through and RAM_STYLE_VAL "block".

Verification
REQ-029 SHALL cover latency: write 0xA5A5A5A5 into an empty block with out_ready=1 -> out_valid in cycle N+3 with out_data=0xA5A5A5A5; count goes 1 then 0.
REQ-030 SHALL cover full: DEPTH=4, out_ready=0, write 0..5 -> 2 words in buffer and 4 in memory, count=6, in_ready=0; the 7th word is not accepted.
REQ-031 SHALL cover wrap: DEPTH=4, continuously stream 0..19 with random out_ready -> output is exactly 0..19 in order.
REQ-032 SHALL cover simultaneous accept/pop: steady state, both handshakes in one cycle -> count unchanged, order preserved.
REQ-033 SHALL cover clear mid-read: pulse clear in the cycle a read is issued -> next cycle count=0 and out_valid=0; the discarded rdata never appears.
REQ-034 SHALL cover reset mid-stream: drop reset_n with 3 words held -> outputs go to reset values immediately; after release, new word 0x1 emerges first.
